// File: rtl/wave_monitor_if.sv
// Sample stream into the waveform monitor and the measurement results coming back.
// The generator side is the master; the monitor itself is the slave.
interface wave_monitor_if;
  logic        sample_valid;
  logic [7:0]  sample_in;
  logic        rising;
  logic        peak_pulse;
  logic        trough_pulse;
  logic [7:0]  peak_val;
  logic [7:0]  trough_val;
  logic [7:0]  min_val;
  logic [7:0]  max_val;
  logic [15:0] period;
  logic        period_valid;
  logic        period_sat;

  modport master (
    output sample_valid, sample_in,
    input  rising, peak_pulse, trough_pulse, peak_val, trough_val,
           min_val, max_val, period, period_valid, period_sat
  );

  modport slave (
    input  sample_valid, sample_in,
    output rising, peak_pulse, trough_pulse, peak_val, trough_val,
           min_val, max_val, period, period_valid, period_sat
  );
endinterface

// File: rtl/wave_monitor.sv
// Tracks a sampled waveform: peak/trough detection with reversal hysteresis,
// running min/max, and the accepted-sample period between successive peaks.
module wave_monitor #(
  parameter int unsigned HYST = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  wave_monitor_if.slave  mon
);

  typedef enum logic [1:0] {IDLE, RISING, FALLING} state_t;

  state_t      state_q;
  logic [7:0]  ext_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [7:0]  peak_val_q, trough_val_q, min_val_q, max_val_q;
  logic [15:0] period_q;
  logic        rising_q, peak_pulse_q, trough_pulse_q, period_valid_q, period_sat_q;
  logic        seen_peak_q;

  logic        accept;
  logic [8:0]  up_diff, down_diff;
  logic        peak_hit, trough_hit, sat_hit;

  // Differences are taken at 9 bits and only used when the sign is known positive.
  always_comb begin
    accept     = mon.sample_valid;
    up_diff    = {1'b0, mon.sample_in} - {1'b0, ext_q};
    down_diff  = {1'b0, ext_q} - {1'b0, mon.sample_in};
    peak_hit   = accept && (state_q == RISING) && (mon.sample_in < ext_q)
                 && (down_diff > 9'(HYST));
    trough_hit = accept && (state_q == FALLING) && (mon.sample_in > ext_q)
                 && (up_diff > 9'(HYST));
    cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    sat_hit    = accept && !peak_hit && (cnt_q == 16'hFFFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ext_q          <= 8'd0;
      cnt_q          <= 16'd0;
      peak_val_q     <= 8'd0;
      trough_val_q   <= 8'd0;
      min_val_q      <= 8'hFF;
      max_val_q      <= 8'd0;
      period_q       <= 16'd0;
      rising_q       <= 1'b1;
      peak_pulse_q   <= 1'b0;
      trough_pulse_q <= 1'b0;
      period_valid_q <= 1'b0;
      period_sat_q   <= 1'b0;
      seen_peak_q    <= 1'b0;
    end else if (clear) begin
      state_q        <= IDLE;
      ext_q          <= 8'd0;
      cnt_q          <= 16'd0;
      peak_val_q     <= 8'd0;
      trough_val_q   <= 8'd0;
      min_val_q      <= 8'hFF;
      max_val_q      <= 8'd0;
      period_q       <= 16'd0;
      rising_q       <= 1'b1;
      peak_pulse_q   <= 1'b0;
      trough_pulse_q <= 1'b0;
      period_valid_q <= 1'b0;
      period_sat_q   <= 1'b0;
      seen_peak_q    <= 1'b0;
    end else begin
      peak_pulse_q   <= 1'b0;
      trough_pulse_q <= 1'b0;
      period_valid_q <= 1'b0;
      if (accept) begin
        if (mon.sample_in < min_val_q) min_val_q <= mon.sample_in;
        if (mon.sample_in > max_val_q) max_val_q <= mon.sample_in;
        cnt_q <= peak_hit ? 16'd1 : cnt_d;
        if (sat_hit) period_sat_q <= 1'b1;
        case (state_q)
          IDLE: begin
            ext_q    <= mon.sample_in;
            state_q  <= RISING;
            rising_q <= 1'b1;
          end
          RISING: begin
            if (mon.sample_in >= ext_q) begin
              ext_q <= mon.sample_in;
            end else if (peak_hit) begin
              peak_val_q   <= ext_q;
              peak_pulse_q <= 1'b1;
              ext_q        <= mon.sample_in;
              state_q      <= FALLING;
              rising_q     <= 1'b0;
              seen_peak_q  <= 1'b1;
              // The very first peak only starts the period measurement.
              if (seen_peak_q) begin
                period_q       <= cnt_q;
                period_valid_q <= 1'b1;
              end
            end
          end
          FALLING: begin
            if (mon.sample_in <= ext_q) begin
              ext_q <= mon.sample_in;
            end else if (trough_hit) begin
              trough_val_q   <= ext_q;
              trough_pulse_q <= 1'b1;
              ext_q          <= mon.sample_in;
              state_q        <= RISING;
              rising_q       <= 1'b1;
            end
          end
          default: begin
            state_q  <= IDLE;
            rising_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mon.rising       = rising_q;
  assign mon.peak_pulse   = peak_pulse_q;
  assign mon.trough_pulse = trough_pulse_q;
  assign mon.peak_val     = peak_val_q;
  assign mon.trough_val   = trough_val_q;
  assign mon.min_val      = min_val_q;
  assign mon.max_val      = max_val_q;
  assign mon.period       = period_q;
  assign mon.period_valid = period_valid_q;
  assign mon.period_sat   = period_sat_q;

endmodule

// File: tb/tb_wave_monitor.sv
// Directed bench for wave_monitor: a vector table for single-step behaviour plus
// hand-written ramp, gap, saturation, clear and mid-run reset sequences.
module tb_wave_monitor;

  logic clk;
  logic rst;
  logic clear;
  int   checks;
  int   errors;

  wave_monitor_if ifc ();

  wave_monitor #(.HYST(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .mon   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [7:0]  smp;
    logic        rising;
    logic        pp;
    logic        tp;
    logic [7:0]  pk;
    logic [7:0]  tr;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic        pvld;
    logic [15:0] per;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] wave[34];

  function automatic vec_t mk(input logic c, input logic v, input logic [7:0] s,
                              input logic r, input logic pp, input logic tp,
                              input logic [7:0] pk, input logic [7:0] tr,
                              input logic [7:0] mn, input logic [7:0] mx,
                              input logic pvld, input logic [15:0] per);
    vec_t t;
    t.clr = c; t.vld = v; t.smp = s; t.rising = r; t.pp = pp; t.tp = tp;
    t.pk = pk; t.tr = tr; t.mn = mn; t.mx = mx; t.pvld = pvld; t.per = per;
    return t;
  endfunction

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge take it, then sample 1 time unit later.
  task automatic applyStimulus(input logic c, input logic v, input logic [7:0] s);
    clear            = c;
    ifc.sample_valid = v;
    ifc.sample_in    = s;
    @(posedge clk);
    #1;
    clear            = 1'b0;
    ifc.sample_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input vec_t e);
    checkVal({tag, ".rising"},       16'(ifc.rising),       16'(e.rising));
    checkVal({tag, ".peak_pulse"},   16'(ifc.peak_pulse),   16'(e.pp));
    checkVal({tag, ".trough_pulse"}, 16'(ifc.trough_pulse), 16'(e.tp));
    checkVal({tag, ".peak_val"},     16'(ifc.peak_val),     16'(e.pk));
    checkVal({tag, ".trough_val"},   16'(ifc.trough_val),   16'(e.tr));
    checkVal({tag, ".min_val"},      16'(ifc.min_val),      16'(e.mn));
    checkVal({tag, ".max_val"},      16'(ifc.max_val),      16'(e.mx));
    checkVal({tag, ".period_valid"}, 16'(ifc.period_valid), 16'(e.pvld));
    checkVal({tag, ".period"},       ifc.period,            e.per);
  endtask

  task automatic checkReset(input string tag);
    checkOutput(tag, mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 1'b0, 16'd0));
    checkVal({tag, ".period_sat"}, 16'(ifc.period_sat), 16'd0);
  endtask

  // Two-peak ramp: peaks land on indices 11 and 33, the trough on index 22.
  task automatic runWave(input int maxGap, input bit doClear, input string tag);
    if (doClear) applyStimulus(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 34; i++) begin
      int gap;
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 1'b0, 8'($urandom));
        checkVal($sformatf("%s.gap%0d.strobes", tag, i),
                 16'({ifc.peak_pulse, ifc.trough_pulse, ifc.period_valid}), 16'd0);
      end
      applyStimulus(1'b0, 1'b1, wave[i]);
      checkVal($sformatf("%s.i%0d.peak_pulse", tag, i), 16'(ifc.peak_pulse),
               16'((i == 11) || (i == 33)));
      checkVal($sformatf("%s.i%0d.trough_pulse", tag, i), 16'(ifc.trough_pulse), 16'(i == 22));
      checkVal($sformatf("%s.i%0d.period_valid", tag, i), 16'(ifc.period_valid), 16'(i == 33));
      if (i == 11) begin
        checkVal({tag, ".i11.peak_val"}, 16'(ifc.peak_val), 16'd100);
        checkVal({tag, ".i11.rising"},   16'(ifc.rising),   16'd0);
      end
      if (i == 22) checkVal({tag, ".i22.trough_val"}, 16'(ifc.trough_val), 16'd0);
    end
    checkVal({tag, ".period"},   ifc.period,          16'd22);
    checkVal({tag, ".peak_val"}, 16'(ifc.peak_val),   16'd100);
    checkVal({tag, ".min_val"},  16'(ifc.min_val),    16'd0);
    checkVal({tag, ".max_val"},  16'(ifc.max_val),    16'd100);
    checkVal({tag, ".rising"},   16'(ifc.rising),     16'd0);
  endtask

  initial begin
    int k;
    int strobeCount;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear = 1'b0;
    ifc.sample_valid = 1'b0;
    ifc.sample_in = 8'd0;

    vecs[0]  = mk(1, 0, 8'd0,   1, 0, 0, 8'd0,  8'd0,  8'hFF, 8'd0,  0, 16'd0);
    vecs[1]  = mk(0, 1, 8'd50,  1, 0, 0, 8'd0,  8'd0,  8'd50, 8'd50, 0, 16'd0);
    vecs[2]  = mk(0, 1, 8'd49,  1, 0, 0, 8'd0,  8'd0,  8'd49, 8'd50, 0, 16'd0);
    vecs[3]  = mk(0, 1, 8'd48,  1, 0, 0, 8'd0,  8'd0,  8'd48, 8'd50, 0, 16'd0);
    vecs[4]  = mk(0, 1, 8'd47,  0, 1, 0, 8'd50, 8'd0,  8'd47, 8'd50, 0, 16'd0);
    vecs[5]  = mk(0, 0, 8'd200, 0, 0, 0, 8'd50, 8'd0,  8'd47, 8'd50, 0, 16'd0);
    vecs[6]  = mk(0, 1, 8'd48,  0, 0, 0, 8'd50, 8'd0,  8'd47, 8'd50, 0, 16'd0);
    vecs[7]  = mk(0, 1, 8'd49,  0, 0, 0, 8'd50, 8'd0,  8'd47, 8'd50, 0, 16'd0);
    vecs[8]  = mk(0, 1, 8'd50,  1, 0, 1, 8'd50, 8'd47, 8'd47, 8'd50, 0, 16'd0);
    vecs[9]  = mk(0, 1, 8'd60,  1, 0, 0, 8'd50, 8'd47, 8'd47, 8'd60, 0, 16'd0);
    vecs[10] = mk(0, 1, 8'd58,  1, 0, 0, 8'd50, 8'd47, 8'd47, 8'd60, 0, 16'd0);
    vecs[11] = mk(0, 1, 8'd57,  0, 1, 0, 8'd60, 8'd47, 8'd47, 8'd60, 1, 16'd6);
    vecs[12] = mk(0, 0, 8'd0,   0, 0, 0, 8'd60, 8'd47, 8'd47, 8'd60, 0, 16'd6);

    k = 0;
    for (int v = 0; v <= 100; v += 10) begin wave[k] = 8'(v); k++; end
    wave[k] = 8'd90; k++;
    for (int v = 80; v >= 0; v -= 10) begin wave[k] = 8'(v); k++; end
    wave[k] = 8'd0; k++;
    for (int v = 10; v <= 100; v += 10) begin wave[k] = 8'(v); k++; end
    wave[k] = 8'd100; k++;
    wave[k] = 8'd90;

    #1;
    checkReset("por");
    #11;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].vld, vecs[i].smp);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    runWave(0, 1'b1, "ramp");

    // Abandon a half-finished waveform with an asynchronous reset.
    applyStimulus(1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd50);
    applyStimulus(1'b0, 1'b1, 8'd60);
    applyStimulus(1'b0, 1'b1, 8'd70);
    applyStimulus(1'b0, 1'b1, 8'd40);
    checkVal("midrst.pre_peak", 16'(ifc.peak_pulse), 16'd1);
    rst = 1'b1;
    #1;
    checkReset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    runWave(3, 1'b0, "gaps");

    // Saturation: after one peak, hold the input inside the hysteresis band.
    applyStimulus(1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd130);
    applyStimulus(1'b0, 1'b1, 8'd127);
    checkVal("sat.first_peak", 16'(ifc.peak_pulse), 16'd1);
    strobeCount = 0;
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b0, 1'b1, 8'd128);
      if (ifc.peak_pulse || ifc.trough_pulse || ifc.period_valid) strobeCount++;
    end
    checkVal("sat.strobes", 16'(strobeCount), 16'd0);
    checkVal("sat.period_sat", 16'(ifc.period_sat), 16'd1);
    applyStimulus(1'b0, 1'b1, 8'd200);
    checkVal("sat.trough", 16'(ifc.trough_pulse), 16'd1);
    applyStimulus(1'b0, 1'b1, 8'd150);
    checkVal("sat.period_valid", 16'(ifc.period_valid), 16'd1);
    checkVal("sat.period", ifc.period, 16'hFFFF);
    checkVal("sat.sticky", 16'(ifc.period_sat), 16'd1);

    // Clear wins over a simultaneous sample and forgets the earlier peak.
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkVal("clr.sat_cleared", 16'(ifc.period_sat), 16'd0);
    applyStimulus(1'b0, 1'b1, 8'd10);
    applyStimulus(1'b0, 1'b1, 8'd20);
    applyStimulus(1'b0, 1'b1, 8'd30);
    applyStimulus(1'b0, 1'b1, 8'd20);
    checkVal("clr.pre_peak", 16'(ifc.peak_pulse), 16'd1);
    applyStimulus(1'b0, 1'b1, 8'd40);
    applyStimulus(1'b0, 1'b1, 8'd50);
    applyStimulus(1'b1, 1'b1, 8'd250);
    checkReset("clr");
    applyStimulus(1'b0, 1'b1, 8'd40);
    checkOutput("clr.first", mk(0, 1, 8'd40, 1, 0, 0, 8'd0, 8'd0, 8'd40, 8'd40, 0, 16'd0));
    applyStimulus(1'b0, 1'b1, 8'd30);
    checkOutput("clr.peak", mk(0, 1, 8'd30, 0, 1, 0, 8'd40, 8'd0, 8'd30, 8'd40, 0, 16'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_monitor.md
WAVE_MONITOR -- requirements
Module: wave_monitor

Interface
REQ-001 SHALL have parameter: HYST, 2, reversal hysteresis in LSBs (legal 0..127).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: clear  input  1  synchronous clear of all measurement state.
REQ-005 SHALL have port: sample_valid  input  1  sample_in is accepted this cycle.
REQ-006 SHALL have port: sample_in  input  8  unsigned waveform sample from the function generator.
REQ-007 SHALL have port: rising  output  1  current tracked direction (1 = rising, 0 = falling).
REQ-008 SHALL have port: peak_pulse  output  1  one-cycle strobe on each detected maximum.
REQ-009 SHALL have port: trough_pulse  output  1  one-cycle strobe on each detected minimum.
REQ-010 SHALL have port: peak_val  output  8  value of the last detected maximum.
REQ-011 SHALL have port: trough_val  output  8  value of the last detected minimum.
REQ-012 SHALL have port: min_val  output  8  lowest accepted sample since reset or clear.
REQ-013 SHALL have port: max_val  output  8  highest accepted sample since reset or clear.
REQ-014 SHALL have port: period  output  16  accepted-sample count between the last two peaks.
REQ-015 SHALL have port: period_valid  output  1  one-cycle strobe when period updates.
REQ-016 SHALL have port: period_sat  output  1  sticky flag: period counter saturated.

Function
REQ-017 SHALL implement FSM states IDLE, RISING and FALLING, plus an 8-bit extreme register ext and a 16-bit sample counter cnt.
REQ-018 SHALL, in IDLE on an accepted sample s: ext<=s, go to RISING, no strobe.
REQ-019 SHALL, in RISING on an accepted sample s: if s>=ext then ext<=s; else if ext-s>HYST then peak_val<=ext, peak_pulse, ext<=s, go to FALLING; else no change.
REQ-020 SHALL, in FALLING on an accepted sample s: if s<=ext then ext<=s; else if s-ext>HYST then trough_val<=ext, trough_pulse, ext<=s, go to RISING; else no change.
REQ-021 SHALL compute all differences at 9-bit width with no wrap-around; the hysteresis comparison is strictly greater-than.
REQ-022 SHALL register all outputs, so strobes and updated values appear in the cycle after the clock edge that accepted the causing sample.
REQ-023 SHALL hold strobes high for exactly one cycle and deassert them in any cycle with no event.
REQ-024 SHALL increment cnt by 1 on each accepted sample and load cnt<=1 on a peak-detecting sample.
REQ-025 SHALL, on the second and later peaks only, load period<=cnt (value before the reload) and pulse period_valid.
REQ-026 SHALL saturate cnt at 16'hFFFF, set period_sat, and hold period_sat until reset or clear.
REQ-027 SHALL update min_val and max_val on every accepted sample, including the first.
REQ-028 SHALL ignore sample_in when sample_valid=0; the FSM, counters and strobes hold or idle.
REQ-029 SHALL give clear priority over a simultaneous sample_valid; that sample is dropped.
REQ-030 SHALL make rising equal 1 in IDLE and RISING and 0 in FALLING.

Reset
REQ-031 SHALL, on rst asserted (asynchronously) or clear (synchronously), enter IDLE with ext=0, cnt=0, peak_val=0, trough_val=0, min_val=8'hFF, max_val=0, period=0, all strobes=0, period_sat=0, rising=1.
REQ-032 SHALL clear the "first peak seen" flag on rst or clear, so the next peak produces no period_valid.
REQ-033 SHALL make rst asserted mid-waveform immediately abandon the in-progress detection; the next sample after release behaves as the first sample.

Verification
REQ-034 SHALL pass: HYST=2, samples 0,10,...,100,90 (indices 0..11) -> peak_pulse after index 11, peak_val=100, no period_valid, rising=0.
REQ-035 SHALL pass: continue 80..0, then 10 (index 22) -> trough_pulse, trough_val=0; continue up to 100, then 90 (index 33) -> peak_pulse and period_valid with period=22; min_val=0, max_val=100.
REQ-036 SHALL pass: RISING with ext=50, samples 49,48 -> no strobe; next sample 47 -> peak_pulse, peak_val=50.
REQ-037 SHALL pass: sample_valid gaps of random length inserted in REQ-035 -> identical strobe sequence and period=22.
REQ-038 SHALL pass: constant sample 128 for 70000 accepted samples after one peak -> no strobes, period_sat=1, cnt held at 16'hFFFF.
REQ-039 SHALL pass: clear with sample_valid=1 mid-ramp -> all outputs at reset values next cycle; the following sample behaves as the first sample.
